// File: rtl/bytecode_fetch_pkg.sv
// Shared constants for the bytecode fetch stage (address width, default depth, empty byte).
package bytecode_fetch_pkg;

  localparam int         BCF_ADDR_W        = 16;
  localparam int         BCF_DEFAULT_DEPTH = 4;
  localparam logic [7:0] BCF_NOP_BYTE      = 8'h00;

endpackage

// File: rtl/bytecode_fetch_if.sv
// Bytecode memory read port: single-outstanding req/ack with data returned on the ack cycle.
interface bytecode_fetch_if
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDR_W = BCF_ADDR_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/bytecode_fetch_fifo.sv
// bcf_fifo: DEPTHx8 synchronous FIFO with push, pop, flush; head reads as the NOP byte when empty.
module bcf_fifo
  import bytecode_fetch_pkg::*;
#(
  parameter int DEPTH = BCF_DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [7:0]       head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = empty ? BCF_NOP_BYTE : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      // pointers wrap naturally because DEPTH is a power of two
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BCF_NOP_BYTE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bytecode_fetch.sv
// Prefetching bytecode fetch stage feeding JVM decode; BCF_PREFETCH_EN enables fetching up to
// DEPTH bytes ahead, otherwise one byte is fetched on demand.
//
// state   | meaning
// ST_IDLE | no request outstanding
// ST_REQ  | request held on the bus until mem_ack; discard_q marks its data stale
module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDR_W = BCF_ADDR_W,
  parameter int DEPTH  = BCF_DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  bytecode_fetch_if.master  mem,
  output logic [7:0]        iram_data,
  output logic              waiting,
  input  logic              advance,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef BCF_PREFETCH_EN
  localparam int ISSUE_LIMIT = DEPTH;
`else
  localparam int ISSUE_LIMIT = 1;
`endif

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              can_issue;

  bcf_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mem.mem_rdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (iram_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign mem.mem_req  = (state_q == ST_REQ);
  assign mem.mem_addr = mem_addr_q;
  assign waiting      = fifo_empty;
  assign pc           = pc_q;
  assign can_issue    = !fifo_full && (fifo_count < CNT_W'(ISSUE_LIMIT));

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    fetch_ptr_d = fetch_ptr_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    if (redirect) begin
      fifo_flush  = 1'b1;
      pc_d        = redirect_pc;
      fetch_ptr_d = redirect_pc;
      // the in-flight handshake completes normally; only its byte is dropped
      if (state_q == ST_REQ) begin
        if (mem.mem_ack) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end else begin
          discard_d = 1'b1;
        end
      end
    end else begin
      fifo_pop = advance && !fifo_empty;
      if (fifo_pop) pc_d = pc_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (can_issue) begin
            state_d    = ST_REQ;
            mem_addr_d = fetch_ptr_q;
          end
        end
        default: begin
          if (mem.mem_ack) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
            if (!discard_q) begin
              fifo_push   = 1'b1;
              fetch_ptr_d = fetch_ptr_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      discard_q   <= 1'b0;
      fetch_ptr_q <= '0;
      pc_q        <= '0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      fetch_ptr_q <= fetch_ptr_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
    end
  end
endmodule

// File: tb/tb_bytecode_fetch.sv
// Scoreboard bench for bytecode_fetch: directed stimulus queues expected (pc, byte) pairs and
// request addresses; independent monitors compare them against what the DUT presents.
module tb_bytecode_fetch;
  import bytecode_fetch_pkg::*;

  localparam int AW = 16;
`ifdef BCF_PREFETCH_EN
  localparam int EFF = 4;
`else
  localparam int EFF = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          advance = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [7:0]    iram_data;
  logic          waiting;
  logic [AW-1:0] pc;

  bytecode_fetch_if #(.ADDR_W(AW)) mem_if ();

  bytecode_fetch #(.ADDR_W(AW), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mem_if.master),
    .iram_data   (iram_data),
    .waiting     (waiting),
    .advance     (advance),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            ack_lat = 0;
  int            req_count = 0;
  logic [23:0]   exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] held_addr = '0;
  logic          prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // memory model: byte at address A is A[7:0]+0x10, acked ack_lat cycles after the request
  initial begin
    int cnt;
    cnt = 0;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset || !mem_if.mem_req) begin
        mem_if.mem_ack = 1'b0;
        cnt = 0;
      end else if (!mem_if.mem_ack) begin
        if (cnt >= ack_lat) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_if.mem_addr[7:0] + 8'h10;
        end else begin
          cnt++;
        end
      end
    end
  end

  // request monitor: each new request must target the next expected address and stay stable
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_if.mem_req && !prev_req) begin
        check("req_addr", 32'(mem_if.mem_addr), 32'(exp_addr));
        held_addr = exp_addr;
        exp_addr  = exp_addr + 16'd1;
        req_count++;
      end else if (mem_if.mem_req && prev_req) begin
        check("req_hold", 32'(mem_if.mem_addr), 32'(held_addr));
      end
      prev_req = mem_if.mem_req;
    end
  end

  // consumer monitor: every byte popped must match the next scoreboard entry
  always @(negedge clk) begin
    logic [23:0] e;
    if (!reset && advance && !waiting && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=pc %0h data %0h required=no pop", pc, iram_data);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", 32'(pc), 32'(e[23:8]));
        check("pop_data", 32'(iram_data), 32'(e[7:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pop_n(input int n);
    int   taken;
    int   budget;
    logic will;
    taken   = 0;
    budget  = 300;
    advance = 1'b1;
    while (taken < n && budget > 0) begin
      @(negedge clk);
      will = !waiting;
      @(posedge clk);
      #1;
      if (will) taken++;
      budget--;
    end
    advance = 1'b0;
    if (taken < n) timeout("pop_n");
  endtask

  task automatic wait_pending_req();
    int budget;
    budget = 100;
    do begin
      @(negedge clk);
      budget--;
    end while (!(mem_if.mem_req && !mem_if.mem_ack) && budget > 0);
    if (budget == 0) timeout("wait_req");
    step();
  endtask

  task automatic do_redirect(input logic [AW-1:0] a, input logic adv);
    redirect    = 1'b1;
    redirect_pc = a;
    advance     = adv;
    exp_q.delete();
    exp_addr    = a;
    step();
    redirect    = 1'b0;
    advance     = 1'b0;
  endtask

  initial begin
    int budget;
    repeat (3) step();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_iram_data", 32'(iram_data), 32'(BCF_NOP_BYTE));
    check("rst_waiting", 32'(waiting), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check("first_req", 32'(mem_if.mem_req), 32'd1);

    // fill with advance low: requests stop once the effective depth is reached
    repeat (20) step();
    check("fill_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("fill_req_count", 32'(req_count), 32'(EFF));
    check("fill_last_addr", 32'(mem_if.mem_addr), 32'(EFF - 1));
    check("fill_waiting", 32'(waiting), 32'd0);
    check("fill_iram_data", 32'(iram_data), 32'h10);
    check("fill_pc", 32'(pc), 32'd0);

    // continuous popping overlapping zero-latency acks
    for (int i = 0; i < 10; i++) expect_byte(AW'(i), 8'(8'h10 + i));
    pop_n(10);
    check("drain_pc", 32'(pc), 32'd10);

    // redirect while a slow request is outstanding: its byte must be discarded
    ack_lat = 3;
    expect_byte(16'h000A, 8'h1A);
    pop_n(1);
    wait_pending_req();
    do_redirect(16'h0200, 1'b0);
    check("redir_pc", 32'(pc), 32'h0200);
    budget = 60;
    forever begin
      @(negedge clk);
      check("redir_waiting", 32'(waiting), 32'd1);
      if (mem_if.mem_req && mem_if.mem_addr == 16'h0200 && mem_if.mem_ack) break;
      budget--;
      if (budget == 0) begin
        timeout("redir_ack");
        break;
      end
    end
    @(negedge clk);
    check("redir_land_waiting", 32'(waiting), 32'd0);
    check("redir_land_data", 32'(iram_data), 32'h10);
    check("redir_land_pc", 32'(pc), 32'h0200);
    step();
    expect_byte(16'h0200, 8'h10);
    expect_byte(16'h0201, 8'h11);
    pop_n(2);

    // fetch pointer and pc wrap through 0xFFFF
    ack_lat = 0;
    do_redirect(16'hFFFE, 1'b0);
    expect_byte(16'hFFFE, 8'h0E);
    expect_byte(16'hFFFF, 8'h0F);
    expect_byte(16'h0000, 8'h10);
    expect_byte(16'h0001, 8'h11);
    pop_n(4);
    check("wrap_pc", 32'(pc), 32'h0002);

    // advance coincident with redirect and held high through the empty window
    ack_lat = 5;
    do_redirect(16'h0300, 1'b1);
    check("stall_pc", 32'(pc), 32'h0300);
    check("stall_waiting", 32'(waiting), 32'd1);
    expect_byte(16'h0300, 8'h10);
    expect_byte(16'h0301, 8'h11);
    pop_n(2);
    check("stall_pc_after", 32'(pc), 32'h0302);

    // reset in the middle of an outstanding request
    wait_pending_req();
    reset = 1'b1;
    exp_q.delete();
    exp_addr = '0;
    step();
    @(negedge clk);
    check("rst_mid_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_mid_waiting", 32'(waiting), 32'd1);
    check("rst_mid_pc", 32'(pc), 32'd0);
    step();
    reset = 1'b0;
    expect_byte(16'h0000, 8'h10);
    pop_n(1);
    check("rst_mid_pc_after", 32'(pc), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Prefetching bytecode fetch stage that sits directly upstream of the JVM decode/iterate state machine. It reads bytecode bytes from the bytecode memory through a req/ack handshake and buffers them in a small FIFO. It presents the head byte on `iram_data` and raises `waiting` whenever no byte is available. It also tracks the JVM PC of the head byte and accepts branch redirects that flush the buffer.

## Interface

- `ADDR_W`, 16, width of bytecode addresses and PC
- `DEPTH`, 4, prefetch FIFO entries; power of two, ≥2
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_req`  out  1  read request to bytecode memory
- `mem_addr`  out  ADDR_W  byte address of current request
- `mem_ack`  in  1  request accepted; `mem_rdata` valid this cycle
- `mem_rdata`  in  8  returned bytecode byte
- `iram_data`  out  8  head byte of FIFO; 0 when empty
- `waiting`  out  1  high when FIFO empty (consumer must stall)
- `advance`  in  1  consumer pops head byte this edge
- `redirect`  in  1  branch taken; flush and refetch from `redirect_pc`
- `redirect_pc`  in  ADDR_W  new PC, sampled when `redirect` high
- `pc`  out  ADDR_W  address of byte on `iram_data`

## Operation

- Reset values:
  - `mem_req`=0, `mem_addr`=0, `iram_data`=0, `waiting`=1, `pc`=0
  - fetch pointer 0, FIFO empty, no request outstanding, discard flag 0
- Request issue:
  - At most one outstanding request.
  - Issue when not outstanding and count < DEPTH.
  - `mem_req` rises with `mem_addr` = fetch pointer.
  - `mem_req` and `mem_addr` are held stable until the edge where `mem_ack`=1.
- Completion:
  - On an ack edge, `mem_rdata` is pushed to the FIFO unless the discard flag is set.
  - The fetch pointer increments only when the byte is kept.
  - `mem_req` drops for at least one cycle.
- Pop:
  - `advance`=1 with `waiting`=0 removes the head byte and increments `pc`.
  - `advance` while `waiting`=1 is ignored.
- Simultaneous push and pop on the same edge: count is unchanged, and both take effect.
- Full: with count = DEPTH, no new request; an outstanding request is impossible by the issue rule.
- Redirect:
  - Highest priority.
  - The FIFO is cleared, and `pc` and the fetch pointer are set to `redirect_pc`.
  - A coincident `advance` is ignored.
  - If a request is outstanding (including one acked on the same edge), its data is discarded: set the discard flag, which clears on the next ack.
  - `mem_req`/`mem_addr` keep the old request until it is acked; the handshake is never aborted.
- Wrap-around: the fetch pointer and `pc` wrap from 2^ADDR_W−1 to 0; FIFO pointers wrap modulo DEPTH.
- Reset mid-request: everything returns to reset values and the pending ack is not waited for. The memory side must tolerate a dropped `mem_req`.

## Timing

- First request: `mem_req`=1 in the first cycle after `reset` deasserts.
- Ack-to-data latency:
  - A byte acked at edge N appears on `iram_data` with `waiting`=0 after edge N.
  - The next request can assert after edge N+1.
- Pop latency: after an `advance` edge, `iram_data` shows the next byte, or 0 with `waiting`=1 if the FIFO is now empty.
- Redirect: `waiting`=1 starting the cycle after the redirect edge. The earliest valid byte appears one cycle after the first non-discarded ack.
- Outputs are registered or derived from registered FIFO state only, with no combinational path from `advance`/`redirect` to `iram_data`. `mem_req` depends on registered state only.

## Configuration

- `BCF_PREFETCH_EN` defined:
  - Prefetch up to DEPTH bytes ahead.
  - Requests are issued whenever space is available, per the rules above.
- Not defined:
  - Effective depth is 1: fetch-on-demand, and `DEPTH` is ignored.
  - A request is issued only when the FIFO is empty and nothing is outstanding.
  - Redirect, discard and PC rules are unchanged.

## Structure

- Shared constants header (`me_consts.vh`) gains:
  - `BCF_DEFAULT_DEPTH`, `BCF_ADDR_W`
  - the NOP/empty byte value (0)
- One sub-module, `bcf_fifo`:
  - synchronous DEPTH×8 FIFO with push, pop and flush
  - count, empty and full outputs
  - simultaneous push/pop support
- `bytecode_fetch` holds the request FSM (IDLE, REQ, with the discard flag as a modifier), the fetch pointer and `pc`.

## Test plan

- Reset, then `mem_ack` returns 0x10, 0x11, 0x12 with 0-cycle ack latency, and `advance` is held low. Required: `mem_addr` steps 0, 1, 2, 3; requests stop at count=4 (with `BCF_PREFETCH_EN`); `iram_data`=0x10, `pc`=0.
- Pop on the same edge as an ack with count=4 → 0: no overflow, no lost byte, sequence in order, `pc` increments by 1 per pop.
- `redirect`=1, `redirect_pc`=0x0200, while a request to 0x0005 is pending with a 3-cycle ack delay. Required:
  - the 0x0005 data is discarded
  - the next `mem_addr`=0x0200
  - `waiting`=1 until that byte lands
  - `pc`=0x0200
- `redirect_pc`=0xFFFE: fetch addresses 0xFFFE, 0xFFFF, 0x0000, and `pc` wraps identically.
- `advance` held high while `waiting`=1: `pc` and the FIFO are unchanged and no byte is skipped.
- Assert `reset` while a request is outstanding. Required: the next cycle shows `mem_req`=0 and `waiting`=1, and the first post-reset request is to 0x0000.
